// File: rtl/mem_arbiter.sv
// Two-port memory arbiter with lock ownership, lock timeout and registered read-valid.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; the default build uses fixed priority (port 0 wins).
//   state | meaning
//   IDLE  | no owner, arbitrate between requesters
//   LOCK0 | port 0 owns the bus, port 1 stalls
//   LOCK1 | port 1 owns the bus, port 0 stalls
module mem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              lock_timeout,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int CNT_W = $clog2(LOCK_MAX + 2);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             last_q, last_d;
  logic             blk_q, blk_d;
  logic             blk_port_q, blk_port_d;
  logic             to_q, to_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic             win1;

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    blk_d      = blk_q;
    blk_port_d = blk_port_q;
    to_d       = 1'b0;
    cnt_inc    = cnt_q + 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    win1 = ~last_q;
`else
    win1 = 1'b0;
`endif
    // a port that just timed out yields the next contention so the other side gets through
    if (blk_q) win1 = ~blk_port_q;

    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          gnt0 = ~win1;
          gnt1 = win1;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      LOCK0:   gnt0 = req0;
      LOCK1:   gnt1 = req1;
      default: ;
    endcase
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (gnt0 && lock0 && !(blk_q && !blk_port_q)) begin
          state_d = LOCK0;
          cnt_d   = CNT_W'(1);
        end else if (gnt1 && lock1 && !(blk_q && blk_port_q)) begin
          state_d = LOCK1;
          cnt_d   = CNT_W'(1);
        end
        if (blk_q && ((gnt1 && !blk_port_q) || (gnt0 && blk_port_q) || !(gnt0 || gnt1)))
          blk_d = 1'b0;
      end
      LOCK0, LOCK1: begin
        if (cnt_inc >= CNT_W'(LOCK_MAX)) begin
          state_d    = IDLE;
          cnt_d      = '0;
          to_d       = 1'b1;
          blk_d      = 1'b1;
          blk_port_d = (state_q == LOCK1);
        end else if ((state_q == LOCK0 && !lock0) || (state_q == LOCK1 && !lock1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (gnt0)      last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;

    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      blk_q      <= 1'b0;
      blk_port_q <= 1'b0;
      to_q       <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      blk_q      <= blk_d;
      blk_port_q <= blk_port_d;
      to_q       <= to_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign mem_we       = gnt0 ? we0    : (gnt1 ? we1    : 1'b0);
  assign mem_addr     = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign mem_data     = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);
  assign rvalid0      = rvalid0_q;
  assign rvalid1      = rvalid1_q;
  assign rdata0       = rvalid0_q ? mem_out : '0;
  assign rdata1       = rvalid1_q ? mem_out : '0;
  assign lock_timeout = to_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a scripted driver queues expected grants, read data and
// timeout pulses tagged with their cycle; a negedge monitor pops and compares them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [5:0]  addr0 = 0, addr1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, lock_timeout, mem_we;
  logic [15:0] rdata0, rdata1, mem_data;
  logic [5:0]  mem_addr;
  logic [15:0] mem_out = 0;
  logic [15:0] mem [64];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .lock_timeout(lock_timeout),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) mem[i] = 16'h0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_out <= mem[mem_addr];
  end

  typedef struct { int cyc; bit port; bit we; logic [5:0] addr; logic [15:0] data; } gexp_t;
  typedef struct { int cyc; logic [15:0] data; } rexp_t;

  gexp_t exp_g[$];
  rexp_t exp_r0[$];
  rexp_t exp_r1[$];
  int    exp_to[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;
  bit    mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: cycle %0d got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit r0, input bit w0, input bit l0, input int a0, input int d0,
                     input bit r1, input bit w1, input bit l1, input int a1, input int d1);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = 6'(a0); wdata0 = 16'(d0);
    req1 = r1; we1 = w1; lock1 = l1; addr1 = 6'(a1); wdata1 = 16'(d1);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic eg(input bit p, input bit w, input int a, input int d);
    gexp_t e;
    e.cyc = cyc; e.port = p; e.we = w; e.addr = 6'(a); e.data = 16'(d);
    exp_g.push_back(e);
  endtask

  task automatic er(input bit p, input int d);
    rexp_t e;
    e.cyc = cyc + 1; e.data = 16'(d);
    if (p) exp_r1.push_back(e);
    else   exp_r0.push_back(e);
  endtask

  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    int    t;
    if (mon_en) begin
      chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
      if (gnt0 || gnt1) begin
        n_vec++;
        if (exp_g.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_gnt: cycle %0d gnt0=%b gnt1=%b addr=%0d", cyc, gnt0, gnt1, mem_addr);
        end else begin
          g = exp_g.pop_front();
          if (g.cyc != cyc || g.port !== gnt1 || g.we !== mem_we || g.addr !== mem_addr || g.data !== mem_data) begin
            n_err++;
            $display("FAIL grant: got cyc=%0d port=%0d we=%b addr=%0d data=%h want cyc=%0d port=%0d we=%b addr=%0d data=%h",
                     cyc, gnt1, mem_we, mem_addr, mem_data, g.cyc, g.port, g.we, g.addr, g.data);
          end
        end
      end else begin
        chk("bus_idle", 32'({mem_we, mem_addr, mem_data}), 32'd0);
      end
      if (rvalid0) begin
        n_vec++;
        if (exp_r0.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rvalid0: cycle %0d rdata0=%h", cyc, rdata0);
        end else begin
          r = exp_r0.pop_front();
          if (r.cyc != cyc || r.data !== rdata0) begin
            n_err++;
            $display("FAIL rdata0: got cyc=%0d data=%h want cyc=%0d data=%h", cyc, rdata0, r.cyc, r.data);
          end
        end
      end else chk("rdata0_zero", 32'(rdata0), 32'd0);
      if (rvalid1) begin
        n_vec++;
        if (exp_r1.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rvalid1: cycle %0d rdata1=%h", cyc, rdata1);
        end else begin
          r = exp_r1.pop_front();
          if (r.cyc != cyc || r.data !== rdata1) begin
            n_err++;
            $display("FAIL rdata1: got cyc=%0d data=%h want cyc=%0d data=%h", cyc, rdata1, r.cyc, r.data);
          end
        end
      end else chk("rdata1_zero", 32'(rdata1), 32'd0);
      if (lock_timeout) begin
        n_vec++;
        if (exp_to.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_timeout: cycle %0d lock_timeout=1 want 0", cyc);
        end else begin
          t = exp_to.pop_front();
          if (t != cyc) begin
            n_err++;
            $display("FAIL timeout_cycle: got %0d want %0d", cyc, t);
          end
        end
      end
    end
  end

  initial begin
    // reset with a pending write request: grants and memory write must stay off
    drv(1, 1, 0, 3, 16'hDEAD, 1, 0, 0, 4, 0);
    tick();
    mon_en = 1;
    tick();
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    chk("rst_timeout", 32'(lock_timeout), 32'd0);
    rst_n = 1'b1;

    // single write then read-back on port 0, then the same on port 1
    drv(1, 1, 0, 5, 16'h00AB, 0, 0, 0, 0, 0); eg(0, 1, 5, 16'h00AB); tick();
    drv(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);        eg(0, 0, 5, 0); er(0, 16'h00AB); tick();
    drv(0, 0, 0, 0, 0, 1, 1, 0, 7, 16'h1234); eg(1, 1, 7, 16'h1234); tick();
    drv(0, 0, 0, 0, 0, 1, 0, 0, 7, 0);        eg(1, 0, 7, 0); er(1, 16'h1234); tick();
    idle(); tick();

    // four cycles of contention
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 0, 5, 0, 1, 0, 0, 7, 0);
`ifdef ARB_ROUND_ROBIN_EN
      if (i % 2 == 0) begin eg(0, 0, 5, 0); er(0, 16'h00AB); end
      else begin eg(1, 0, 7, 0); er(1, 16'h1234); end
`else
      eg(0, 0, 5, 0); er(0, 16'h00AB);
`endif
      tick();
    end
    drv(0, 0, 0, 0, 0, 1, 0, 0, 7, 0); eg(1, 0, 7, 0); er(1, 16'h1234); tick();
    idle(); tick();

    // port 1 lock: three writes while port 0 waits, including one idle locked cycle
    drv(0, 0, 0, 10, 0, 1, 1, 1, 10, 16'h0A0A); eg(1, 1, 10, 16'h0A0A); tick();
    drv(1, 0, 0, 10, 0, 1, 1, 1, 11, 16'h0B0B); eg(1, 1, 11, 16'h0B0B); tick();
    drv(1, 0, 0, 10, 0, 0, 0, 1, 12, 0); tick();
    drv(1, 0, 0, 10, 0, 1, 1, 0, 12, 16'h0C0C); eg(1, 1, 12, 16'h0C0C); tick();
    drv(1, 0, 0, 10, 0, 0, 0, 0, 0, 0); eg(0, 0, 10, 0); er(0, 16'h0A0A); tick();
    drv(0, 0, 0, 0, 0, 1, 0, 0, 12, 0); eg(1, 0, 12, 0); er(1, 16'h0C0C); tick();
    idle(); tick();

    // port 0 holds lock past LOCK_MAX: 8 grants, timeout pulse, port 1 served, then port 0 relocks
    for (int i = 1; i <= 12; i++) begin
      drv(1, 1, (i != 12), 20, 16'h5555, (i <= 9), 0, 0, 11, 0);
      if (i == 9) begin eg(1, 0, 11, 0); er(1, 16'h0B0B); end
      else eg(0, 1, 20, 16'h5555);
      if (i == 8) exp_to.push_back(cyc + 1);
      tick();
    end
    idle(); tick();

    // reset during LOCK1 with a read request outstanding
    drv(0, 0, 0, 0, 0, 1, 1, 1, 30, 16'h7777); eg(1, 1, 30, 16'h7777); tick();
    rst_n = 1'b0;
    drv(1, 0, 0, 30, 0, 1, 0, 1, 30, 0);
    #1;
    chk("rst_lock_gnt0", 32'(gnt0), 32'd0);
    chk("rst_lock_gnt1", 32'(gnt1), 32'd0);
    chk("rst_lock_mem_we", 32'(mem_we), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("post_rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("post_rst_timeout", 32'(lock_timeout), 32'd0);
    drv(1, 0, 0, 30, 0, 1, 0, 0, 30, 0); eg(0, 0, 30, 0); er(0, 16'h7777); tick();
    drv(0, 0, 0, 0, 0, 1, 0, 0, 30, 0);  eg(1, 0, 30, 0); er(1, 16'h7777); tick();
    idle(); tick(); tick(); tick();

    chk("leftover_gnt", 32'(exp_g.size()), 32'd0);
    chk("leftover_rd0", 32'(exp_r0.size()), 32'd0);
    chk("leftover_rd1", 32'(exp_r1.size()), 32'd0);
    chk("leftover_timeout", 32'(exp_to.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 6, memory address width.
REQ-002 The module SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 The module SHALL have parameter LOCK_MAX, default 8, maximum consecutive cycles one port may hold a lock.
REQ-004 The module SHALL have one clock; reset is synchronous and active-low: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req0, req1  in  1 each  access request, port 0 (CPU) and port 1 (loader/IO).
REQ-007 we0, we1  in  1 each  write enable of the request.
REQ-008 addr0, addr1  in  ADDR_W each  request address.
REQ-009 wdata0, wdata1  in  DATA_W each  write data.
REQ-010 lock0, lock1  in  1 each  keep ownership after the current access.
REQ-011 gnt0, gnt1  out  1 each  access accepted this cycle.
REQ-012 rvalid0, rvalid1  out  1 each  read data valid.
REQ-013 rdata0, rdata1  out  DATA_W each  read data.
REQ-014 lock_timeout  out  1  one-cycle pulse on forced lock release.
REQ-015 mem_we, mem_addr, mem_data  out  1/ADDR_W/DATA_W  memory write enable, address, write data.
REQ-016 mem_out  in  DATA_W  memory read data, valid one cycle after address presented.

Function
REQ-017 Grants SHALL be combinational from current state and req0/req1; at most one gnt high per cycle; access completes at the rising edge ending the gnt cycle.
REQ-018 Requester SHALL hold req/we/addr/wdata stable until gnt; may change them on the edge ending the gnt cycle; back-to-back accesses allowed with no bubble.
REQ-019 Granted port's we/addr/wdata SHALL drive mem_we/mem_addr/mem_data; with no grant mem_we=0, mem_addr=0, mem_data=0.
REQ-020 FSM states SHALL be IDLE, LOCK0, LOCK1.
REQ-021 In IDLE, a single requester SHALL be granted; contention resolved per REQ-033/034.
REQ-022 A gntX cycle with lockX=1 SHALL move FSM to LOCKX at that edge and load lock counter with 1.
REQ-023 In LOCKX only port X SHALL be granted; other port stalls; reqX=0 with lockX=1 gives an idle bus, state held.
REQ-024 LOCKX SHALL exit to IDLE at an edge where lockX=0; an access granted in that cycle still completes.
REQ-025 Lock counter SHALL increment each LOCKX cycle; at edge where counter==LOCK_MAX FSM SHALL go to IDLE, lock_timeout pulses the following cycle, and port X cannot re-lock until one other-port grant or one idle IDLE cycle.
REQ-026 rvalidX SHALL be registered gntX & ~weX (1-cycle latency); rdataX = mem_out when rvalidX, else 0.
REQ-027 Write-then-read to same address on consecutive cycles SHALL return the written data.
REQ-028 Simultaneous lock request by both ports in IDLE: only the granted port locks.

Reset
REQ-029 With rst_n=0 at an edge: state IDLE, lock counter 0, rvalid0/1=0, lock_timeout=0, last-grant register=1.
REQ-030 While rst_n=0, gnt0/gnt1 and mem_we SHALL be forced 0.
REQ-031 Reset mid-lock or with a read in flight SHALL discard the response; no rvalid after reset.

Configuration
REQ-032 Macro ARB_ROUND_ROBIN_EN SHALL select arbitration policy.
REQ-033 Without ARB_ROUND_ROBIN_EN: fixed priority, port 0 wins every IDLE contention.
REQ-034 With ARB_ROUND_ROBIN_EN: port not granted last wins contention; last-grant register updates on every grant; after reset port 0 wins first.

Verification
REQ-035 Single: req0, we0=1, addr0=5, wdata0=0x00AB -> gnt0 same cycle, mem_we=1, mem_addr=5; next read addr0=5 -> rvalid0 next cycle, rdata0=0x00AB.
REQ-036 Contention, macro off: req0=req1=1 for 4 cycles -> gnt0 all 4, gnt1 0; macro on -> gnt0,gnt1,gnt0,gnt1.
REQ-037 Lock: port1 lock1=1, 3 writes addr 10..12 while req0=1 -> gnt1 x3, gnt0 0 until lock1 drops, then gnt0 next cycle.
REQ-038 Timeout: lock0=1, req0=1 held 12 cycles, req1=1 -> 8 gnt0, FSM IDLE, lock_timeout pulse, gnt1 next.
REQ-039 Reset mid-lock: rst_n=0 one edge during LOCK1 with read pending -> gnts 0, rvalid1 0, state IDLE, port 0 granted first after release.
